// File: rtl/hub75_scan_if.sv
// hub75_scan_if: ROM address/data and HUB75 panel pin bundle.
// master = scan controller, slave = ROM + panel side.
interface hub75_scan_if #(
  parameter int XW = 7,
  parameter int YW = 5
);
  logic [XW-1:0] rom_addrx;
  logic [YW-1:0] rom_addry;
  logic [23:0]   rom_data0;
  logic [23:0]   rom_data1;
  logic          hub_clk;
  logic          hub_lat;
  logic          hub_oe_n;
  logic [YW-1:0] hub_row;
  logic [2:0]    hub_rgb0;
  logic [2:0]    hub_rgb1;
  logic          frame_start;
  logic          frame_done;

  modport master (
    output rom_addrx, rom_addry,
    input  rom_data0, rom_data1,
    output hub_clk, hub_lat, hub_oe_n, hub_row,
    output hub_rgb0, hub_rgb1,
    output frame_start, frame_done
  );

  modport slave (
    input  rom_addrx, rom_addry,
    output rom_data0, rom_data1,
    input  hub_clk, hub_lat, hub_oe_n, hub_row,
    input  hub_rgb0, hub_rgb1,
    input  frame_start, frame_done
  );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: dual-half HUB75 scan with BCM bit-planes.
// Reads the sprite ROM per column and weights OE per plane.
module hub75_scan_ctrl #(
  parameter int COLS    = 128,
  parameter int ROWS    = 32,
  parameter int BITS    = 8,
  parameter int OE_BASE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  hub75_scan_if.master bus
);
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int PW = $clog2(BITS);
  localparam int OW = $clog2((OE_BASE << (BITS - 1)) + 1);
  localparam int RL = ROWS - 1;
  localparam int PL = BITS - 1;
  localparam logic [XW:0]   C_END  = COLS[XW:0];
  localparam logic [XW:0]   C_LAST = C_END - 1'b1;
  localparam logic [YW-1:0] R_LAST = RL[YW-1:0];
  localparam logic [PW-1:0] P_LAST = PL[PW-1:0];
  localparam logic [OW-1:0] OE_B   = OE_BASE[OW-1:0];

  typedef enum logic [1:0] {
    S_IDLE, S_SHIFT, S_LATCH, S_DISP
  } state_t;

  state_t        r_state, w_state_n;
  logic [YW-1:0] r_row, w_row_n;
  logic [PW-1:0] r_plane, w_plane_n;
  logic [XW:0]   r_col, w_col_n;
  logic          r_phase, w_phase_n;
  logic [OW-1:0] r_oe_cnt, w_oe_cnt_n;
  logic [XW-1:0] r_addrx, w_addrx_n;
  logic [YW-1:0] r_addry, w_addry_n;
  logic          r_hclk, w_hclk_n;
  logic          r_lat, w_lat_n;
  logic          r_oe_n, w_oe_n_n;
  logic [YW-1:0] r_hrow, w_hrow_n;
  logic [2:0]    r_rgb0, w_rgb0_n;
  logic [2:0]    r_rgb1, w_rgb1_n;
  logic          r_fs, w_fs_n;
  logic          r_fd, w_fd_n;
  logic          w_go_shift;

  logic [OW-1:0] w_oe_len;
  logic [OW-1:0] w_oe_last;
  logic [4:0]    w_pi;
  logic [2:0]    w_px0;
  logic [2:0]    w_px1;

  assign w_oe_len  = OE_B << r_plane;
  assign w_oe_last = w_oe_len - 1'b1;
  assign w_pi      = 5'(r_plane);
  assign w_px0 = {bus.rom_data0[5'd16 + w_pi],
                  bus.rom_data0[5'd8 + w_pi],
                  bus.rom_data0[w_pi]};
  assign w_px1 = {bus.rom_data1[5'd16 + w_pi],
                  bus.rom_data1[5'd8 + w_pi],
                  bus.rom_data1[w_pi]};

  always_comb begin
    w_state_n  = r_state;
    w_row_n    = r_row;
    w_plane_n  = r_plane;
    w_col_n    = r_col;
    w_phase_n  = r_phase;
    w_oe_cnt_n = r_oe_cnt;
    w_addrx_n  = r_addrx;
    w_addry_n  = r_addry;
    w_hclk_n   = r_hclk;
    w_lat_n    = r_lat;
    w_oe_n_n   = r_oe_n;
    w_hrow_n   = r_hrow;
    w_rgb0_n   = r_rgb0;
    w_rgb1_n   = r_rgb1;
    w_fs_n     = 1'b0;
    w_fd_n     = 1'b0;
    w_go_shift = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_go_shift = 1'b1;
          w_row_n    = '0;
          w_plane_n  = '0;
          w_fs_n     = 1'b1;
        end
      end
      S_SHIFT: begin
        w_phase_n = ~r_phase;
        if (r_phase)
          w_col_n = r_col + 1'b1;
        // odd cycle: ROM data for r_col is valid now
        if (r_phase && r_col < C_END) begin
          w_rgb0_n = w_px0;
          w_rgb1_n = w_px1;
          w_hclk_n = 1'b0;
          if (r_col < C_LAST)
            w_addrx_n = r_addrx + 1'b1;
        end
        if (!r_phase && r_col != '0)
          w_hclk_n = 1'b1;
        if (r_phase && r_col == C_END) begin
          w_state_n = S_LATCH;
          w_hclk_n  = 1'b0;
          w_lat_n   = 1'b1;
          w_hrow_n  = r_row;
        end
      end
      S_LATCH: begin
        w_state_n  = S_DISP;
        w_lat_n    = 1'b0;
        w_oe_n_n   = 1'b0;
        w_oe_cnt_n = '0;
      end
      S_DISP: begin
        w_oe_cnt_n = r_oe_cnt + 1'b1;
        if (r_oe_cnt == w_oe_last) begin
          w_oe_n_n = 1'b1;
          if (r_plane != P_LAST) begin
            w_plane_n  = r_plane + 1'b1;
            w_go_shift = 1'b1;
          end else if (r_row != R_LAST) begin
            w_plane_n  = '0;
            w_row_n    = r_row + 1'b1;
            w_go_shift = 1'b1;
          end else begin
            w_plane_n = '0;
            w_row_n   = '0;
            w_fd_n    = 1'b1;
            w_state_n = S_IDLE;
          end
        end
      end
    endcase
    if (w_go_shift) begin
      w_state_n = S_SHIFT;
      w_col_n   = '0;
      w_phase_n = 1'b0;
      w_addrx_n = '0;
      w_addry_n = w_row_n;
      w_hclk_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_plane  <= '0;
      r_col    <= '0;
      r_phase  <= 1'b0;
      r_oe_cnt <= '0;
      r_addrx  <= '0;
      r_addry  <= '0;
      r_hclk   <= 1'b0;
      r_lat    <= 1'b0;
      r_oe_n   <= 1'b1;
      r_hrow   <= '0;
      r_rgb0   <= '0;
      r_rgb1   <= '0;
      r_fs     <= 1'b0;
      r_fd     <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_row    <= w_row_n;
      r_plane  <= w_plane_n;
      r_col    <= w_col_n;
      r_phase  <= w_phase_n;
      r_oe_cnt <= w_oe_cnt_n;
      r_addrx  <= w_addrx_n;
      r_addry  <= w_addry_n;
      r_hclk   <= w_hclk_n;
      r_lat    <= w_lat_n;
      r_oe_n   <= w_oe_n_n;
      r_hrow   <= w_hrow_n;
      r_rgb0   <= w_rgb0_n;
      r_rgb1   <= w_rgb1_n;
      r_fs     <= w_fs_n;
      r_fd     <= w_fd_n;
    end
  end

  assign bus.rom_addrx   = r_addrx;
  assign bus.rom_addry   = r_addry;
  assign bus.hub_clk     = r_hclk;
  assign bus.hub_lat     = r_lat;
  assign bus.hub_oe_n    = r_oe_n;
  assign bus.hub_row     = r_hrow;
  assign bus.hub_rgb0    = r_rgb0;
  assign bus.hub_rgb1    = r_rgb1;
  assign bus.frame_start = r_fs;
  assign bus.frame_done  = r_fd;
endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl: scoreboard bench with random ROM contents.
// Expected panel events per frame are queued; a monitor pops them.
module tb_hub75_scan_ctrl;
  localparam int COLS    = 8;
  localparam int ROWS    = 4;
  localparam int BITS    = 8;
  localparam int OE_BASE = 2;
  localparam int XW      = $clog2(COLS);
  localparam int YW      = $clog2(ROWS);
  localparam int FRAME   =
    ROWS * (BITS * (2 * COLS + 3) + OE_BASE * ((1 << BITS) - 1));
  localparam int LIM     = 4 * FRAME;

  logic clk;
  logic reset;
  logic enable;

  hub75_scan_if #(.XW(XW), .YW(YW)) bus ();

  hub75_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .BITS(BITS), .OE_BASE(OE_BASE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] rom0 [ROWS][COLS];
  logic [23:0] rom1 [ROWS][COLS];

  initial begin
    bus.rom_data0 = '0;
    bus.rom_data1 = '0;
  end
  always @(posedge clk) begin
    bus.rom_data0 <= rom0[bus.rom_addry][bus.rom_addrx];
    bus.rom_data1 <= rom1[bus.rom_addry][bus.rom_addrx];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the panel must see, row by row, plane by plane
  logic [5:0] px_q[$];
  int         lat_q[$];
  int         oe_q[$];

  function automatic logic [2:0] plane_bits(input logic [23:0] d,
                                            input int b);
    return {d[16+b], d[8+b], d[b]};
  endfunction

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++)
      for (int b = 0; b < BITS; b++) begin
        for (int c = 0; c < COLS; c++)
          px_q.push_back({plane_bits(rom0[r][c], b),
                          plane_bits(rom1[r][c], b)});
        lat_q.push_back(r);
        oe_q.push_back(OE_BASE << b);
      end
  endtask

  // Monitor
  int cyc = 0;
  int edges = 0;
  int total_edges = 0;
  int run = 0;
  int lat_cnt = 0;
  int fs_cnt = 0;
  int fd_cnt = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  bit have_start = 0;
  bit have_done = 0;
  bit prev_clk = 0;
  bit prev_oe_n = 1;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_clk   = 0;
      prev_oe_n  = 1;
      run        = 0;
      edges      = 0;
      have_start = 0;
      have_done  = 0;
    end else begin
      if (bus.hub_clk && !prev_clk) begin
        edges++;
        total_edges++;
        if (px_q.size() == 0)
          check("unexpected_pixel", 1, 0);
        else
          check("pixel", int'({bus.hub_rgb0, bus.hub_rgb1}),
                int'(px_q.pop_front()));
      end
      if (!bus.hub_oe_n)
        run++;
      else if (!prev_oe_n) begin
        if (oe_q.size() == 0)
          check("unexpected_oe_run", run, 0);
        else
          check("oe_run_len", run, oe_q.pop_front());
        run = 0;
      end
      if (bus.hub_lat) begin
        lat_cnt++;
        if (lat_q.size() == 0)
          check("unexpected_latch", int'(bus.hub_row), -1);
        else
          check("latch_row", int'(bus.hub_row), lat_q.pop_front());
        check("edges_before_latch", edges, COLS);
        edges = 0;
      end
      check("pin_rules",
            int'((bus.hub_lat && !bus.hub_oe_n) ||
                 (bus.hub_clk && (bus.hub_lat || !bus.hub_oe_n))), 0);
      if (bus.frame_start) begin
        fs_cnt++;
        if (have_start && have_done && cyc - done_cyc == 1)
          check("start_spacing", cyc - start_cyc, FRAME + 1);
        start_cyc  = cyc;
        have_start = 1;
      end
      if (bus.frame_done) begin
        fd_cnt++;
        if (have_start)
          check("frame_len", cyc - start_cyc, FRAME);
        done_cyc  = cyc;
        have_done = 1;
      end
      prev_clk  = bus.hub_clk;
      prev_oe_n = bus.hub_oe_n;
    end
  end

  // Stimulus
  int i;
  int edges_snap;
  int lat_snap;
  int lat0;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rom0[r][c] = 24'($urandom);
        rom1[r][c] = 24'($urandom);
      end

    repeat (3) @(posedge clk);
    #1;
    check("rst_oe_n", int'(bus.hub_oe_n), 1);
    check("rst_hub_clk", int'(bus.hub_clk), 0);
    check("rst_lat", int'(bus.hub_lat), 0);
    check("rst_row", int'(bus.hub_row), 0);
    check("rst_rgb", int'({bus.hub_rgb0, bus.hub_rgb1}), 0);
    check("rst_addr", int'({bus.rom_addrx, bus.rom_addry}), 0);
    check("rst_pulses", int'({bus.frame_start, bus.frame_done}), 0);

    @(negedge clk);
    #1 reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("idle_oe_n", int'(bus.hub_oe_n), 1);
    check("idle_outputs",
          int'({bus.hub_clk, bus.hub_lat, bus.hub_row,
                bus.frame_start, bus.frame_done}), 0);
    check("idle_edges", total_edges, 0);

    // Two back-to-back frames; enable drops in row ROWS/2 of the second
    push_frame();
    push_frame();
    @(negedge clk);
    enable = 1'b1;
    i = 0;
    while (lat_cnt < BITS * ROWS + BITS * (ROWS / 2) && i < LIM) begin
      @(posedge clk);
      i++;
    end
    check("reach_drop_row_timeout", int'(i < LIM), 1);
    @(negedge clk);
    enable = 1'b0;
    i = 0;
    while (fd_cnt < 2 && i < LIM) begin
      @(posedge clk);
      i++;
    end
    check("second_done_timeout", int'(i < LIM), 1);
    edges_snap = total_edges;
    repeat (50) @(posedge clk);
    #1;
    check("drop_q_empty", px_q.size() + lat_q.size() + oe_q.size(), 0);
    check("drop_fs_cnt", fs_cnt, 2);
    check("drop_fd_cnt", fd_cnt, 2);
    check("drop_oe_n", int'(bus.hub_oe_n), 1);
    check("drop_no_edges", total_edges, edges_snap);

    // Reset in the middle of row 1 plane 0 shift
    push_frame();
    lat0 = lat_cnt;
    @(negedge clk);
    enable = 1'b1;
    i = 0;
    while (!(lat_cnt >= lat0 + BITS && edges >= COLS / 2) && i < LIM) begin
      @(posedge clk);
      i++;
    end
    check("reach_mid_shift_timeout", int'(i < LIM), 1);
    #2 reset = 1'b1;
    #1;
    check("async_oe_n", int'(bus.hub_oe_n), 1);
    check("async_lat", int'(bus.hub_lat), 0);
    check("async_hub_clk", int'(bus.hub_clk), 0);
    px_q.delete();
    lat_q.delete();
    oe_q.delete();
    lat_snap = lat_cnt;
    repeat (5) @(posedge clk);
    #1 check("no_partial_latch", lat_cnt, lat_snap);

    push_frame();
    @(negedge clk);
    #1 reset = 1'b0;
    i = 0;
    while (lat_cnt <= lat_snap && i < LIM) begin
      @(posedge clk);
      i++;
    end
    check("restart_latch_timeout", int'(i < LIM), 1);
    @(negedge clk);
    enable = 1'b0;
    i = 0;
    while (fd_cnt < 3 && i < LIM) begin
      @(posedge clk);
      i++;
    end
    check("restart_done_timeout", int'(i < LIM), 1);
    repeat (20) @(posedge clk);
    #1;
    check("restart_q_empty", px_q.size() + lat_q.size() + oe_q.size(), 0);
    check("restart_fs_cnt", fs_cnt, 4);
    check("restart_oe_n", int'(bus.hub_oe_n), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
